// File: rtl/mux_4_1_scanner.sv
// Walks a mux_4_1 select through 0..3, samples Y after SETTLE_CYCLES per step and packs the bits into a word.
// The word appears 4*SETTLE_CYCLES cycles after start and is held stable until out_ready.
module mux_4_1_scanner #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [1:0] sel,
  input  logic       y_in,
  output logic       busy,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("mux_4_1_scanner: SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    OUTPUT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    sel_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    data_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 2'b00;
      cnt      <= '0;
      out_data <= 4'h0;
    end else begin
      state    <= state_nxt;
      sel      <= sel_nxt;
      cnt      <= cnt_nxt;
      out_data <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          sel_nxt   = 2'b00;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        // y_in is a combinational function of the registered sel, so it has settled by the last count
        if (cnt == CNT_LAST) begin
          data_nxt[sel] = y_in;
          cnt_nxt       = '0;
          if (sel == 2'd3) begin
            state_nxt = OUTPUT;
          end else begin
            sel_nxt = sel + 2'd1;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
          sel_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 2'b00;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUTPUT);

endmodule

// File: tb/tb_mux_4_1_scanner.sv
// Two scanners (settle 1 and settle 3) each wired to a behavioural 4:1 mux; scans are checked cycle by cycle against an arithmetic model.
module tb_mux_4_1_scanner;

  logic       clk;
  logic       rst;
  logic       start     [2];
  logic [1:0] sel       [2];
  logic       y         [2];
  logic       busy      [2];
  logic [3:0] out_data  [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [3:0] mux_dat   [2];

  int checks;
  int failures;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mux_4_1 behaviour: Y = data[sel]
  assign y[0] = mux_dat[0][sel[0]];
  assign y[1] = mux_dat[1][sel[1]];

  mux_4_1_scanner #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .sel(sel[0]), .y_in(y[0]), .busy(busy[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0])
  );

  mux_4_1_scanner #(.SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start[1]), .sel(sel[1]), .y_in(y[1]), .busy(busy[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1])
  );

  task automatic chk(input string tag, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // One scan on instance i: start during cycle 0, settle s cycles per bit, then hold cycles of backpressure.
  task automatic scan(input int i, input logic [3:0] d, input int hold, input bit noisy);
    int s;
    s = settle_of(i);
    @(negedge clk);
    chk("idle_busy", busy[i], 0);
    chk("idle_valid", out_valid[i], 0);
    mux_dat[i]   = d;
    start[i]     = 1'b1;
    out_ready[i] = 1'b0;
    for (int t = 0; t < 4 * s; t++) begin
      @(negedge clk);
      start[i] = noisy ? 1'($urandom) : 1'b0;
      chk("scan_sel", sel[i], t / s);
      chk("scan_busy", busy[i], 1);
      chk("scan_valid", out_valid[i], 0);
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("out_valid", out_valid[i], 1);
      chk("out_data", out_data[i], d);
      chk("out_busy", busy[i], 1);
      chk("out_sel", sel[i], 3);
      if (noisy) mux_dat[i] = 4'($urandom);
      start[i]     = (noisy && h != hold) ? 1'($urandom) : 1'b0;
      out_ready[i] = (h == hold);
    end
    @(negedge clk);
    chk("done_busy", busy[i], 0);
    chk("done_valid", out_valid[i], 0);
    chk("done_sel", sel[i], 0);
    out_ready[i] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i]     = 1'b0;
      out_ready[i] = 1'b0;
      mux_dat[i]   = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_sel", sel[i], 0);
      chk("rst_busy", busy[i], 0);
      chk("rst_valid", out_valid[i], 0);
      chk("rst_data", out_data[i], 0);
    end
    rst = 1'b0;

    scan(0, 4'b1010, 0, 1'b0);
    for (int v = 0; v < 16; v++) scan(0, 4'(v), 0, 1'b0);
    scan(1, 4'b0110, 0, 1'b0);
    scan(0, 4'b1100, 7, 1'b0);
    scan(0, 4'b0101, 5, 1'b1);
    scan(1, 4'b1001, 4, 1'b1);

    // start held high with out_ready high: one idle cycle between back-to-back scans
    @(negedge clk);
    mux_dat[0]   = 4'b1110;
    start[0]     = 1'b1;
    out_ready[0] = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      @(negedge clk);
      chk("rerun_busy", busy[0], (t % 6) != 0);
      if (t % 6 == 5) chk("rerun_data", out_data[0], 4'b1110);
    end
    start[0]     = 1'b0;
    out_ready[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("rerun_stop", busy[0], 0);

    // reset mid-scan, after bit 1 has been captured
    @(negedge clk);
    mux_dat[0] = 4'b1111;
    start[0]   = 1'b1;
    repeat (3) @(negedge clk);
    start[0] = 1'b0;
    chk("pre_rst_sel", sel[0], 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_sel", sel[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_valid", out_valid[0], 0);
    chk("abort_data", out_data[0], 0);
    scan(0, 4'b0011, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      scan(n % 2, 4'($urandom), int'($urandom_range(0, 6)), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
